// File: rtl/cache_mem_arbiter_if.sv
// Shared-RAM port bundle: icache and dcache request/response lines plus the RAM side.
// The arbiter uses the slave modport; the caches/RAM environment uses master.
interface cache_mem_arbiter_if #(
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache word accesses onto one RAM port with a grant watchdog.
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; default is dcache priority.
module cache_mem_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   bus,
    output logic                 timeout
);
    // state     | meaning
    // S_IDLE    | no grant; RAM port idle, new request sampled here
    // S_GRANT_I | icache owns the RAM port until ready, drop or watchdog
    // S_GRANT_D | dcache owns the RAM port until ready, drop or watchdog
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_MAX  = '1;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  wd_cnt, wd_nxt;
    logic              last_grant, last_nxt;
    logic              timeout_nxt;
    logic              ireq, dreq, pick_d;
    logic [WORD_W-1:0] addr_sel, store_sel;

    assign ireq = bus.iREN;
    assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_ROUND_ROBIN_EN
    assign pick_d = ~last_grant;
`else
    assign pick_d = 1'b1;
`endif

    always_comb begin
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        addr_sel   = '0;
        store_sel  = '0;
        case (state)
            S_GRANT_I: begin
                bus.ramREN = bus.iREN;
                addr_sel   = bus.iaddr;
            end
            S_GRANT_D: begin
                bus.ramREN = bus.dREN & ~bus.dWEN;
                bus.ramWEN = bus.dWEN;
                addr_sel   = bus.daddr;
                store_sel  = bus.dstore;
            end
            default: ;
        endcase
    end

    assign bus.ramaddr  = addr_sel;
    assign bus.ramstore = store_sel;
    assign bus.iwait    = ~((state == S_GRANT_I) & bus.ramready & ireq);
    assign bus.dwait    = ~((state == S_GRANT_D) & bus.ramready & dreq);
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;

    always_comb begin
        state_nxt   = state;
        wd_nxt      = wd_cnt;
        last_nxt    = last_grant;
        timeout_nxt = timeout;
        case (state)
            S_IDLE: begin
                wd_nxt = '0;
                if (dreq && ireq) begin
                    state_nxt = pick_d ? S_GRANT_D : S_GRANT_I;
                    last_nxt  = pick_d;
                end else if (dreq) begin
                    state_nxt = S_GRANT_D;
                    last_nxt  = 1'b1;
                end else if (ireq) begin
                    state_nxt = S_GRANT_I;
                    last_nxt  = 1'b0;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                // Completion and requester withdrawal both end the grant silently.
                if (bus.ramready || ((state == S_GRANT_I) ? !ireq : !dreq)) begin
                    state_nxt = S_IDLE;
                    wd_nxt    = '0;
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt   = S_IDLE;
                    wd_nxt      = '0;
                    timeout_nxt = 1'b1;
                end else if (wd_cnt != WD_MAX) begin
                    wd_nxt = wd_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                wd_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            wd_cnt     <= '0;
            last_grant <= 1'b1;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wd_cnt     <= wd_nxt;
            last_grant <= last_nxt;
            timeout    <= timeout_nxt;
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios then random traffic,
// compared every cycle against a grant-owner/cycle-count model of the arbiter.
module tb_cache_mem_arbiter;
    localparam int W  = 32;
    localparam int TO = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic timeout;

    cache_mem_arbiter_if #(.WORD_W(W)) bus ();

    cache_mem_arbiter #(.WORD_W(W), .TIMEOUT(TO), .CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0 = none, 1 = icache, 2 = dcache; gcyc = 1-based grant cycle index.
    int owner = 0;
    int gcyc = 0;
    bit m_to = 1'b0;
    bit m_last_d = 1'b1;

    initial begin
        logic ir, dr, rdy;
        logic [31:0] e_ren, e_wen, e_addr, e_store;
        forever begin
            @(negedge CLK);
            #1;
            if (!nRST) begin
                owner = 0; gcyc = 0; m_to = 1'b0; m_last_d = 1'b1;
            end
            ir  = bus.iREN;
            dr  = bus.dREN | bus.dWEN;
            rdy = bus.ramready;
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
            if (owner == 1) begin
                e_ren = {31'd0, ir};
                e_addr = bus.iaddr;
            end else if (owner == 2) begin
                e_ren = {31'd0, bus.dREN & ~bus.dWEN};
                e_wen = {31'd0, bus.dWEN};
                e_addr = bus.daddr;
                e_store = bus.dstore;
            end
            check("ramREN", {31'd0, bus.ramREN}, e_ren);
            check("ramWEN", {31'd0, bus.ramWEN}, e_wen);
            check("ramaddr", bus.ramaddr, e_addr);
            check("ramstore", bus.ramstore, e_store);
            check("iwait", {31'd0, bus.iwait}, {31'd0, !(owner == 1 && rdy && ir)});
            check("dwait", {31'd0, bus.dwait}, {31'd0, !(owner == 2 && rdy && dr)});
            check("iload", bus.iload, bus.ramload);
            check("dload", bus.dload, bus.ramload);
            check("timeout", {31'd0, timeout}, {31'd0, m_to});
            if (nRST) begin
                case (owner)
                    0: begin
`ifdef ARB_ROUND_ROBIN_EN
                        if (ir && dr) owner = m_last_d ? 1 : 2;
`else
                        if (ir && dr) owner = 2;
`endif
                        else if (dr) owner = 2;
                        else if (ir) owner = 1;
                        if (owner != 0) begin
                            m_last_d = (owner == 2);
                            gcyc = 1;
                        end
                    end
                    default: begin
                        if (rdy || !((owner == 1) ? ir : dr)) owner = 0;
                        else if (gcyc == TO) begin
                            owner = 0;
                            m_to = 1'b1;
                        end else gcyc++;
                    end
                endcase
            end
        end
    end

    initial begin
        int ilow, dlow;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramready = 0;

        repeat (2) @(negedge CLK);
        #2;
        check("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
        check("rst_iwait", {31'd0, bus.iwait}, 32'd1);
        check("rst_dwait", {31'd0, bus.dwait}, 32'd1);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        @(negedge CLK) nRST = 1;

        // icache read
        @(negedge CLK) begin bus.iREN = 1; bus.iaddr = 32'h40; end
        @(negedge CLK) begin bus.ramready = 1; bus.ramload = 32'hDEADBEEF; end
        #2;
        check("i_ramREN", {31'd0, bus.ramREN}, 32'd1);
        check("i_ramaddr", bus.ramaddr, 32'h40);
        check("i_iwait", {31'd0, bus.iwait}, 32'd0);
        check("i_iload", bus.iload, 32'hDEADBEEF);
        check("i_dwait", {31'd0, bus.dwait}, 32'd1);
        @(negedge CLK) begin bus.iREN = 0; bus.ramready = 0; end
        #2;
        check("i_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);

        // dcache write
        @(negedge CLK) begin bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'h12345678; end
        @(negedge CLK) bus.ramready = 1;
        #2;
        check("d_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        check("d_ramstore", bus.ramstore, 32'h12345678);
        check("d_dwait", {31'd0, bus.dwait}, 32'd0);
        @(negedge CLK) begin bus.dWEN = 0; bus.ramready = 0; end
        #2;
        check("d_idle_ramWEN", {31'd0, bus.ramWEN}, 32'd0);

        // both requesting, single-cycle RAM
        @(negedge CLK) begin bus.iREN = 1; bus.dREN = 1; bus.ramready = 1; end
        ilow = 0; dlow = 0;
        repeat (8) begin
            @(negedge CLK);
            #2;
            if (!bus.iwait) ilow++;
            if (!bus.dwait) dlow++;
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("tie_icache_grants", ilow, 32'd2);
        check("tie_dcache_grants", dlow, 32'd2);
`else
        check("tie_icache_grants", ilow, 32'd0);
        check("tie_dcache_grants", dlow, 32'd4);
`endif
        @(negedge CLK) begin bus.iREN = 0; bus.dREN = 0; bus.ramready = 0; end
        @(negedge CLK);

        // watchdog
        @(negedge CLK) begin bus.dREN = 1; bus.daddr = 32'h180; end
        dlow = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            #2;
            if (!bus.dwait) dlow++;
            if (k == 4) check("wd_before", {31'd0, timeout}, 32'd0);
            if (k == 5) check("wd_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
            if (k >= 5) check("wd_timeout", {31'd0, timeout}, 32'd1);
        end
        check("wd_dwait_lows", dlow, 32'd0);
        @(negedge CLK) bus.dREN = 0;
        @(negedge CLK);
        #2;
        check("wd_sticky", {31'd0, timeout}, 32'd1);

        // icache withdraws with dcache pending
        @(negedge CLK) begin bus.iREN = 1; bus.iaddr = 32'h44; end
        @(negedge CLK) begin bus.dREN = 1; bus.daddr = 32'h200; end
        #2;
        check("ab_ramaddr_i", bus.ramaddr, 32'h44);
        @(negedge CLK);
        @(negedge CLK) bus.iREN = 0;
        #2;
        check("ab_ramREN_drop", {31'd0, bus.ramREN}, 32'd0);
        @(negedge CLK);
        #2;
        check("ab_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
        @(negedge CLK) bus.ramready = 1;
        #2;
        check("ab_d_ramREN", {31'd0, bus.ramREN}, 32'd1);
        check("ab_d_ramaddr", bus.ramaddr, 32'h200);
        check("ab_d_dwait", {31'd0, bus.dwait}, 32'd0);
        @(negedge CLK) begin bus.dREN = 0; bus.ramready = 0; end

        // reset mid dcache write grant
        @(negedge CLK) begin bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'hA5A5A5A5; end
        @(negedge CLK);
        #2;
        check("rm_ramWEN_pre", {31'd0, bus.ramWEN}, 32'd1);
        #1 nRST = 0;
        #1;
        check("rm_ramWEN_async", {31'd0, bus.ramWEN}, 32'd0);
        check("rm_ramREN_async", {31'd0, bus.ramREN}, 32'd0);
        check("rm_dwait_async", {31'd0, bus.dwait}, 32'd1);
        @(negedge CLK);
        @(negedge CLK) begin bus.dWEN = 0; nRST = 1; end
        #2;
        check("rm_timeout_clr", {31'd0, timeout}, 32'd0);

        // random traffic
        repeat (3000) begin
            @(negedge CLK);
            if (!nRST) nRST = 1;
            else if ($urandom_range(0, 399) == 0) nRST = 0;
            if (bus.iREN) begin
                if ($urandom_range(0, 7) == 0) bus.iREN = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.iREN = 1;
                bus.iaddr = $urandom;
            end
            if (bus.dREN || bus.dWEN) begin
                if ($urandom_range(0, 7) == 0) begin
                    bus.dREN = 0;
                    bus.dWEN = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.dREN = 1'($urandom_range(0, 1));
                bus.dWEN = ~bus.dREN | 1'($urandom_range(0, 3) == 0);
                bus.daddr = $urandom;
                bus.dstore = $urandom;
            end
            bus.ramready = ($urandom_range(0, 2) == 0);
            bus.ramload = $urandom;
        end

        @(negedge CLK);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
